// File: rtl/sd_block_read.sv
// rtl/sd_block_read.sv - SPI-mode SD single-block (CMD17) reader with byte stream out
// Optional SD_READ_CRC_CHECK_EN: check CRC16-CCITT of the data block against the card's CRC.
module sd_block_read #(
    parameter int R1_TIMEOUT    = 8,
    parameter int TOKEN_TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        initDone,
    input  logic        start,
    input  logic [31:0] blockAddr,
    input  logic        DO,
    output logic        SCLK,
    output logic        DI,
    output logic        CS,
    output logic [7:0]  rdData,
    output logic        rdValid,
    input  logic        rdReady,
    output logic        busy,
    output logic        done,
    output logic [2:0]  error
);

    typedef enum logic [3:0] {
        S_IDLE, S_PRE, S_CMD, S_R1WAIT, S_TOKWAIT, S_DATA, S_CRC, S_POST, S_DONE
    } state_t;

    localparam logic [9:0] R1_LAST  = 10'(R1_TIMEOUT - 1);
    localparam logic [9:0] TOK_LAST = 10'(TOKEN_TIMEOUT - 1);

    state_t      state;
    logic [54:0] tx_sr;     // bits still to send after the one currently on DI
    logic [6:0]  rx_sr;
    logic [2:0]  bit_cnt;
    logic [9:0]  byte_cnt;
    logic [7:0]  rx_byte;

    assign rx_byte = {rx_sr, DO};

`ifdef SD_READ_CRC_CHECK_EN
    logic [15:0] crc_calc;
    logic [15:0] crc_step;
    logic [7:0]  crc_hi;

    always_comb begin
        crc_step = {crc_calc[14:0], 1'b0} ^ ((crc_calc[15] ^ DO) ? 16'h1021 : 16'h0000);
    end
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            SCLK     <= 1'b0;
            DI       <= 1'b1;
            CS       <= 1'b1;
            rdData   <= 8'h00;
            rdValid  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            error    <= 3'd0;
            tx_sr    <= '1;
            rx_sr    <= 7'd0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 10'd0;
`ifdef SD_READ_CRC_CHECK_EN
            crc_calc <= 16'h0000;
            crc_hi   <= 8'h00;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && initDone) begin
                        state    <= S_PRE;
                        CS       <= 1'b0;
                        DI       <= 1'b1;
                        busy     <= 1'b1;
                        error    <= 3'd0;
                        tx_sr    <= {7'h7F, 8'h51, blockAddr, 8'hFF};
                        bit_cnt  <= 3'd0;
                        byte_cnt <= 10'd0;
`ifdef SD_READ_CRC_CHECK_EN
                        crc_calc <= 16'h0000;
`endif
                    end
                end
                S_DONE: state <= S_IDLE;
                default: begin
                    // rdValid only rises in DATA; while it is up SCLK stays low
                    if (rdValid) begin
                        if (rdReady) begin
                            rdValid <= 1'b0;
                            if (byte_cnt == 10'd511) begin
                                state    <= S_CRC;
                                byte_cnt <= 10'd0;
                            end else begin
                                byte_cnt <= byte_cnt + 10'd1;
                            end
                        end
                    end else if (!SCLK) begin
                        SCLK <= 1'b1;
                    end else begin
                        SCLK    <= 1'b0;
                        DI      <= tx_sr[54];
                        tx_sr   <= {tx_sr[53:0], 1'b1};
                        rx_sr   <= rx_byte[6:0];
                        bit_cnt <= bit_cnt + 3'd1;
`ifdef SD_READ_CRC_CHECK_EN
                        if (state == S_DATA) crc_calc <= crc_step;
`endif
                        if (bit_cnt == 3'd7) begin
                            case (state)
                                S_PRE: begin
                                    state    <= S_CMD;
                                    byte_cnt <= 10'd0;
                                end
                                S_CMD: begin
                                    if (byte_cnt == 10'd5) begin
                                        state    <= S_R1WAIT;
                                        byte_cnt <= 10'd0;
                                    end else begin
                                        byte_cnt <= byte_cnt + 10'd1;
                                    end
                                end
                                S_R1WAIT: begin
                                    if (!rx_byte[7]) begin
                                        if (rx_byte == 8'h00) begin
                                            state    <= S_TOKWAIT;
                                            byte_cnt <= 10'd0;
                                        end else begin
                                            error <= 3'd2;
                                            state <= S_POST;
                                            CS    <= 1'b1;
                                        end
                                    end else if (byte_cnt == R1_LAST) begin
                                        error <= 3'd1;
                                        state <= S_POST;
                                        CS    <= 1'b1;
                                    end else begin
                                        byte_cnt <= byte_cnt + 10'd1;
                                    end
                                end
                                S_TOKWAIT: begin
                                    if (rx_byte == 8'hFE) begin
                                        state    <= S_DATA;
                                        byte_cnt <= 10'd0;
                                    end else if (rx_byte[7:4] == 4'h0) begin
                                        error <= 3'd4;
                                        state <= S_POST;
                                        CS    <= 1'b1;
                                    end else if (byte_cnt == TOK_LAST) begin
                                        error <= 3'd3;
                                        state <= S_POST;
                                        CS    <= 1'b1;
                                    end else begin
                                        byte_cnt <= byte_cnt + 10'd1;
                                    end
                                end
                                S_DATA: begin
                                    rdData  <= rx_byte;
                                    rdValid <= 1'b1;
                                end
                                S_CRC: begin
                                    if (byte_cnt == 10'd0) begin
                                        byte_cnt <= 10'd1;
`ifdef SD_READ_CRC_CHECK_EN
                                        crc_hi   <= rx_byte;
`endif
                                    end else begin
                                        state <= S_POST;
                                        CS    <= 1'b1;
`ifdef SD_READ_CRC_CHECK_EN
                                        if ({crc_hi, rx_byte} != crc_calc) error <= 3'd5;
`endif
                                    end
                                end
                                S_POST: begin
                                    state <= S_DONE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                end
                                default: ;
                            endcase
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sd_block_read.sv
// tb/tb_sd_block_read.sv - directed bench for sd_block_read with SD card and read-result model
module tb_sd_block_read;

    localparam int R1_TO  = 8;
    localparam int TOK_TO = 1023;
`ifdef SD_READ_CRC_CHECK_EN
    localparam int CRC_ERR = 5;
`else
    localparam int CRC_ERR = 0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        initDone = 1'b0;
    logic        start = 1'b0;
    logic [31:0] blockAddr = 32'd0;
    logic        DO = 1'b1;
    logic        SCLK, DI, CS;
    logic [7:0]  rdData;
    logic        rdValid;
    logic        rdReady = 1'b1;
    logic        busy, done;
    logic [2:0]  error;

    sd_block_read #(.R1_TIMEOUT(R1_TO), .TOKEN_TIMEOUT(TOK_TO)) dut (
        .clk(clk), .reset(reset), .initDone(initDone), .start(start),
        .blockAddr(blockAddr), .DO(DO), .SCLK(SCLK), .DI(DI), .CS(CS),
        .rdData(rdData), .rdValid(rdValid), .rdReady(rdReady),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vecs++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Card: byte stream from card_tx indexed by bytes clocked since CS fell
    logic [7:0] card_tx [0:2047];
    logic [7:0] card_rx [0:6];
    logic [7:0] crx = 8'h00;
    int  ck = 0, cb = 0;
    logic prev_sclk = 1'b0;

    always @(negedge clk) begin
        if (CS) begin
            ck = 0;
            cb = 0;
            DO = 1'b1;
        end else begin
            if (SCLK && !prev_sclk) crx = {crx[6:0], DI};
            if (!SCLK && prev_sclk) begin
                cb++;
                if (cb == 8) begin
                    if (ck < 7) card_rx[ck] = crx;
                    cb = 0;
                    ck++;
                end
            end
            DO = (ck < 2048) ? card_tx[ck][7 - cb] : 1'b1;
        end
        prev_sclk = SCLK;
    end

    function automatic logic [15:0] crc16_at(input int base);
        logic [15:0] c;
        logic [7:0]  b;
        logic        fb;
        c = 16'h0000;
        for (int k = 0; k < 512; k++) begin
            b = card_tx[base + k];
            for (int j = 7; j >= 0; j--) begin
                fb = c[15] ^ b[j];
                c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        end
        return c;
    endfunction

    task automatic load_card(input int r1_at, input logic [7:0] r1_v, input int tok_at,
                             input logic [7:0] tok_v, input bit ramp, input bit good_crc,
                             input logic [15:0] crc_v);
        logic [15:0] c;
        for (int i = 0; i < 2048; i++) card_tx[i] = 8'hFF;
        if (r1_at >= 0) card_tx[r1_at] = r1_v;
        if (tok_at >= 0) begin
            card_tx[tok_at] = tok_v;
            if (tok_v == 8'hFE) begin
                for (int k = 0; k < 512; k++) card_tx[tok_at + 1 + k] = ramp ? 8'(k * 7 + 3) : 8'hFF;
                c = good_crc ? crc16_at(tok_at + 1) : crc_v;
                card_tx[tok_at + 513] = c[15:8];
                card_tx[tok_at + 514] = c[7:0];
            end
        end
    endtask

    // Expected outcome from the card contents: error code, byte count, data start, latency
    int m_err, m_nb, m_base, m_lat;

    task automatic model();
        int polls, idx;
        bit found;
        logic [7:0] b;
        m_err = 0; m_nb = 0; m_base = 0; polls = 0; found = 0; idx = 7;
        for (int i = 0; i < R1_TO && !found; i++) begin
            polls++;
            b = card_tx[7 + i];
            if (!b[7]) begin
                found = 1;
                idx = 8 + i;
                if (b != 8'h00) m_err = 2;
            end
        end
        if (!found) m_err = 1;
        if (m_err == 0) begin
            found = 0;
            for (int j = 0; j < TOK_TO && !found; j++) begin
                polls++;
                b = card_tx[idx + j];
                if (b == 8'hFE) begin
                    found = 1;
                    m_base = idx + j + 1;
                    m_nb = 512;
                end else if (b[7:4] == 4'h0) begin
                    found = 1;
                    m_err = 4;
                end
            end
            if (!found) m_err = 3;
        end
        m_lat = 112 + 16 * polls + 16 + ((m_nb != 0) ? 512 * 17 + 32 : 0);
        if (m_nb != 0 && CRC_ERR != 0 &&
            crc16_at(m_base) != {card_tx[m_base + 512], card_tx[m_base + 513]}) m_err = CRC_ERR;
    endtask

    // Output monitor
    int  acc_cnt = 0, pulses = 0, done_cnt = 0;
    int  cyc = 0, cs_fall_cyc = 0, done_cyc = 0;
    bit  stalling = 0;
    logic [7:0] stall_data = 8'h00;
    logic prev_valid = 1'b0, prev_cs = 1'b1;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rdValid && !prev_valid) pulses++;
        if (rdValid && rdReady) begin
            if (acc_cnt < 512) chk($sformatf("rd_data[%0d]", acc_cnt), rdData, card_tx[m_base + acc_cnt]);
            else chk("rd_extra_byte", acc_cnt, 511);
            acc_cnt++;
        end
        if (stalling) chk("stall_hold", {SCLK, rdValid, rdData}, {1'b0, 1'b1, stall_data});
        if (!CS && prev_cs) cs_fall_cyc = cyc;
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        prev_valid = rdValid;
        prev_cs = CS;
    end

    task automatic kick(input logic [31:0] addr);
        @(posedge clk);
        #1;
        acc_cnt = 0; pulses = 0; done_cnt = 0;
        blockAddr = addr;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (done_cnt == 0 && n < 25000) begin
            @(posedge clk);
            n++;
        end
        if (done_cnt == 0) chk({name, "_done_timeout"}, 0, 1);
    endtask

    task automatic check_end(input string name, input bit chk_lat);
        repeat (3) @(posedge clk);
        #1;
        chk({name, "_error"}, error, m_err);
        chk({name, "_done_pulses"}, done_cnt, 1);
        chk({name, "_bytes"}, acc_cnt, m_nb);
        chk({name, "_valid_pulses"}, pulses, m_nb);
        chk({name, "_idle_pins"}, {CS, SCLK, DI, busy, done, rdValid}, 6'b101000);
        if (chk_lat) chk({name, "_latency"}, done_cyc - cs_fall_cyc, m_lat);
    endtask

    task automatic run(input string name, input logic [31:0] addr, input int lit_err);
        model();
        chk({name, "_model_err"}, m_err, lit_err);
        kick(addr);
        wait_done(name);
        check_end(name, 1'b1);
    endtask

    initial begin
        logic [55:0] exp_cmd;
        int n;

        repeat (2) @(negedge clk);
        chk("reset_vals", {SCLK, DI, CS, rdData, rdValid, busy, done, error},
            {1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0});
        @(posedge clk);
        #1 reset = 1'b1;
        load_card(-1, 8'hFF, -1, 8'hFF, 0, 0, 16'h0);

        // start ignored while initDone low
        start = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("no_init_busy", {busy, CS}, 2'b01);
        start = 1'b0;
        initDone = 1'b1;

        // nominal read, all-0xFF block, block 16
        load_card(8, 8'h00, 12, 8'hFE, 0, 0, 16'h7FA1);
        chk("crc_model_ff", crc16_at(13), 16'h7FA1);
        run("ok_ff", 32'd16, 0);
        chk("ok_ff_lat_literal", m_lat, 8960);
        exp_cmd = 56'hFF_51_00000010_FF;
        chk("cmd_bytes", {card_rx[0], card_rx[1], card_rx[2], card_rx[3], card_rx[4], card_rx[5], card_rx[6]}, exp_cmd);

        load_card(8, 8'h00, 12, 8'hFE, 0, 0, 16'h1234);
        run("bad_crc", 32'h0000_0020, CRC_ERR);

        load_card(7, 8'h04, -1, 8'hFF, 0, 0, 16'h0);
        run("r1_nonzero", 32'h1234_5678, 2);

        load_card(-1, 8'hFF, -1, 8'hFF, 0, 0, 16'h0);
        run("r1_timeout", 32'd1, 1);

        load_card(7, 8'h00, -1, 8'hFF, 0, 0, 16'h0);
        run("tok_timeout", 32'd2, 3);

        load_card(7, 8'h00, 8, 8'h08, 0, 0, 16'h0);
        run("tok_error", 32'd3, 4);

        // consumer stall on byte 100
        load_card(7, 8'h00, 8, 8'hFE, 1, 1, 16'h0);
        model();
        chk("stall_model_err", m_err, 0);
        kick(32'hCAFE_0001);
        n = 0;
        while (acc_cnt < 100 && n < 5000) begin
            @(posedge clk);
            n++;
        end
        #1 rdReady = 1'b0;
        n = 0;
        while (!rdValid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("stall_valid_seen", rdValid, 1'b1);
        stall_data = rdData;
        stalling = 1;
        repeat (50) @(posedge clk);
        #1;
        stalling = 0;
        rdReady = 1'b1;
        wait_done("stall");
        check_end("stall", 1'b0);

        // reset during byte 200, then a clean read
        kick(32'd77);
        n = 0;
        while (acc_cnt < 200 && n < 6000) begin
            @(posedge clk);
            n++;
        end
        #1 reset = 1'b0;
        @(negedge clk);
        chk("mid_reset_pins", {CS, SCLK, busy, rdValid, done}, 5'b10000);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_reset_no_done", done_cnt, 0);
        run("after_reset", 32'd78, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

// File: doc/sd_block_read.md
# sd_block_read

SPI-mode SD card single-block reader: issues CMD17 for a given block, waits for R1 and the start-data token, and streams the 512 data bytes out over a valid/ready byte interface with backpressure. It is the read-side counterpart of the SD write path. It runs after card initialisation has completed and owns SCLK/DI/CS only while busy. Upstream consumers, such as a display buffer or FIFO, pull bytes at their own pace.

## Interface
Parameters:
- `R1_TIMEOUT`, default 8: number of bytes polled for the R1 response before giving up.
- `TOKEN_TIMEOUT`, default 1023: number of bytes polled for the data token before giving up.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-low reset.
- `initDone`  in  1  card initialisation finished; `start` is ignored while low.
- `start`  in  1  level request; sampled in IDLE only.
- `blockAddr`  in  32  CMD17 argument (block number), captured on accept.
- `DO`  in  1  card MISO.
- `SCLK`  out  1  SPI clock.
- `DI`  out  1  card MOSI.
- `CS`  out  1  chip select, active-low.
- `rdData`  out  8  data byte.
- `rdValid`  out  1  `rdData` is valid.
- `rdReady`  in  1  consumer accepts the byte.
- `busy`  out  1  transaction in progress.
- `done`  out  1  transaction ended; see `error`.
- `error`  out  3  0 = ok, 1 = R1 timeout, 2 = R1 nonzero, 3 = token timeout, 4 = data-error token, 5 = CRC mismatch.

## Operation
- Bit engine:
  - SCLK = clk/2, idles low.
  - DI updates on SCLK falling edge; DO is sampled on SCLK rising edge.
  - Bits are sent and received MSB first.
  - One SPI bit = 2 clk.
- States:
  - IDLE: CS=1, DI=1, SCLK=0. If `start` && `initDone`: capture `blockAddr`, raise `busy`, clear `done` and `error`, go to PRE.
  - PRE: CS=0, send 8 bits of 1.
  - CMD: send 48 bits: 0x51, `blockAddr`[31:0], 0xFF.
  - R1WAIT: clock in bytes with DI=1.
    - The first byte with bit7=0 is R1.
    - R1==0x00 goes to TOKWAIT; any other value sets error 2 and goes to POST.
    - After `R1_TIMEOUT` bytes with no R1: error 1, go to POST.
  - TOKWAIT: clock in bytes with DI=1.
    - 0xFE goes to DATA.
    - A byte with bits[7:4]==0 sets error 4 and goes to POST.
    - After `TOKEN_TIMEOUT` bytes: error 3, go to POST.
  - DATA: receive 512 bytes.
    - After each byte, set `rdData` and `rdValid`=1.
    - SCLK is held low (clock stretched) until `rdValid`&&`rdReady`, then reception resumes.
    - Byte counter is 10 bits; leave DATA when it reaches 511 and that byte is accepted.
  - CRC: receive 2 bytes (CRC16, MSB first) into a 16-bit register.
  - POST: CS=1, send 8 bits of 1 to release DO.
  - DONE: `busy`=0, `done`=1 for one clk, go to IDLE.
    - `error` holds its value until the next accepted `start`.
- Every error path passes through POST, so CS is always deasserted cleanly.
- Reset mid-transaction: all outputs go to reset values immediately, the state returns to IDLE, and no `done` pulse is produced.
- `start` held high after DONE begins a new transaction on the next IDLE cycle. The consumer must drop `start` to avoid repeat reads.

## Timing
- Reset values: SCLK=0, DI=1, CS=1, `rdData`=0x00, `rdValid`=0, `busy`=0, `done`=0, `error`=0.
- `start` accepted → CS low: 1 clk.
- PRE+CMD: 56 bits = 112 clk.
- Each polled byte: 16 clk.
- Last token bit sampled → first `rdValid`: 16 clk + 1 clk to register.
- `rdValid` rises on the clk after the 8th rising SCLK of the byte. It falls the clk after `rdReady` is seen high. With `rdReady` tied high, the byte rate is one per 17 clk.
- Last CRC bit → POST start: 1 clk.
- POST: 16 clk.
- `done` pulse: 1 clk.
- Minimum full read, no stretch, R1 and token each in their first byte: approximately 112+16+16+512·17+32+16+2 clk.

## Configuration
- `SD_READ_CRC_CHECK_EN` defined:
  - A CRC16-CCITT (poly 0x1021, init 0x0000) is computed over the 512 data bytes in DATA.
  - The computed value is compared to the received CRC at the end of the CRC state.
  - A mismatch sets error 5; POST still executes.
- Not defined:
  - The received CRC bytes are clocked in and discarded.
  - Error 5 is never produced, and no CRC logic is synthesised.

## Test plan
- Card model: R1=0x00 on the 2nd poll byte, 0xFE after 3 bytes, 512×0xFF, CRC 0x7FA1, `rdReady`=1 → CMD bytes seen on DI are 51 00 00 00 10 FF for `blockAddr`=16; exactly 512 `rdValid` pulses of 0xFF; one `done` pulse; `error`=0.
- Same stimulus with CRC 0x1234 → with `SD_READ_CRC_CHECK_EN`: `error`=5, `done`=1, CS high after POST. Without the macro: `error`=0.
- R1=0x04 → `error`=2, no `rdValid` at all, CS returns to 1 within 16 clk after R1 completes.
- DO stuck at 1 → after 8 R1 bytes `error`=1. Repeat with R1=0x00 and no token: after 1023 bytes `error`=3. Token 0x08 instead: `error`=4.
- `rdReady` low for 50 clk on byte 100 → SCLK frozen low, `rdValid` held with a stable `rdData` for the whole stall, byte 101 received correctly afterwards, 512 bytes total.
- `reset` asserted (low) during DATA at byte 200 → next clk CS=1, SCLK=0, `busy`=0, `rdValid`=0, no `done` pulse; a following `start` completes a full read normally.
